thermostat_sequencer: RTL

Clocked controller that sits in front of the combinational thermostat outputs and sequences the heater and air-conditioner loads. It enforces a minimum on-time per run, a minimum off-time (compressor/element lockout) between runs, and a fan run-on after each run. Heat and cool are never driven together, and the block never switches directly from one to the other. Inputs use the same too_hot / too_cold / mode / fan_on encoding as the thermostat; outputs drive the load relays.

---
 rtl/thermostat_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/thermostat_sequencer.sv
// Heater/AC load sequencer: min on-time, off-time lockout, fan run-on; never heats and cools at once.
// Latency: a call sampled at one edge drives its relay from the next cycle. No backpressure; all outputs are registered.
module thermostat_sequencer #(
  parameter int MIN_ON    = 4,
  parameter int MIN_OFF   = 3,
  parameter int FAN_RUNON = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic too_hot,
  input  logic too_cold,
  input  logic mode,
  input  logic fan_on,
  output logic heater,
  output logic aircon,
  output logic fan,
  output logic lockout
);

  localparam int MAX_AB = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
  localparam int MAXV   = (MAX_AB > FAN_RUNON) ? MAX_AB : FAN_RUNON;
  localparam int CW     = $clog2(MAXV + 1);

  localparam logic [CW-1:0] C_MIN_ON  = CW'(MIN_ON);
  localparam logic [CW-1:0] C_MIN_OFF = CW'(MIN_OFF);
  localparam logic [CW-1:0] C_RUNON   = CW'(FAN_RUNON);
  localparam logic [CW-1:0] C_ONE     = CW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HEAT  = 2'd1;
  localparam logic [1:0] S_COOL  = 2'd2;
  localparam logic [1:0] S_RUNON = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [CW-1:0] r_on_cnt;
  logic [CW-1:0] r_off_cnt;
  logic [CW-1:0] r_run_cnt;
  logic          r_heater;
  logic          r_aircon;
  logic          r_fan;

  logic w_heat_call;
  logic w_cool_call;
  logic w_lockout;
  logic w_start_heat;
  logic w_start_cool;
  logic w_on_done;
  logic w_run_done;
  logic w_in_run;
  logic w_next_run;
  logic w_leave_run;

  // Both temperature flags set at once is a sensor fault and must never start a load.
  assign w_heat_call  = mode & too_cold & ~too_hot;
  assign w_cool_call  = ~mode & too_hot & ~too_cold;
  assign w_lockout    = (r_off_cnt != '0);
  assign w_start_heat = w_heat_call & ~w_lockout;
  assign w_start_cool = w_cool_call & ~w_lockout;
  assign w_on_done    = (r_on_cnt >= C_MIN_ON);
  assign w_run_done   = (r_run_cnt >= C_RUNON);
  assign w_in_run     = (r_state == S_HEAT) || (r_state == S_COOL);
  assign w_next_run   = (w_next == S_HEAT) || (w_next == S_COOL);
  assign w_leave_run  = w_in_run && (w_next != r_state);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_heat)      w_next = S_HEAT;
        else if (w_start_cool) w_next = S_COOL;
      end
      S_HEAT: begin
        if (!w_heat_call && w_on_done) w_next = (FAN_RUNON == 0) ? S_IDLE : S_RUNON;
      end
      S_COOL: begin
        if (!w_cool_call && w_on_done) w_next = (FAN_RUNON == 0) ? S_IDLE : S_RUNON;
      end
      S_RUNON: begin
        // A fresh call beats run-on expiry, but only once the lockout has cleared.
        if (w_start_heat)      w_next = S_HEAT;
        else if (w_start_cool) w_next = S_COOL;
        else if (w_run_done)   w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_on_cnt  <= '0;
      r_off_cnt <= '0;
      r_run_cnt <= '0;
      r_heater  <= 1'b0;
      r_aircon  <= 1'b0;
      r_fan     <= 1'b0;
    end else begin
      r_state <= w_next;

      if (!w_next_run)                 r_on_cnt <= '0;
      else if (w_next != r_state)      r_on_cnt <= C_ONE;
      else if (!w_on_done)             r_on_cnt <= r_on_cnt + C_ONE;

      if (w_next != S_RUNON)           r_run_cnt <= '0;
      else if (r_state != S_RUNON)     r_run_cnt <= C_ONE;
      else if (!w_run_done)            r_run_cnt <= r_run_cnt + C_ONE;

      if (w_leave_run)                 r_off_cnt <= C_MIN_OFF;
      else if (w_lockout)              r_off_cnt <= r_off_cnt - C_ONE;

      r_heater <= (w_next == S_HEAT);
      r_aircon <= (w_next == S_COOL);
      r_fan    <= (w_next == S_IDLE) ? fan_on : 1'b1;
    end
  end

  assign heater  = r_heater;
  assign aircon  = r_aircon;
  assign fan     = r_fan;
  assign lockout = w_lockout;

endmodule
